muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the EX stage.
- Accepts MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO requests from EX and runs iterative shift-add multiply and restoring divide.
- Asserts Stall so the pipeline holds while the resource is busy.
- Replaces single-cycle HI/LO handling in EX; EX forwards ReadData as Result for MFHI/MFLO.

---
 rtl/muldiv_unit.sv | 237 +++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide sequencer that owns the HI/LO pair.
// It runs a shift-add multiply or a restoring divide, one bit per cycle, on
// operand magnitudes. A final FIX cycle then applies the result signs and
// writes HI/LO.
`timescale 1ns/1ps

module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] Rdata1,
  input  logic [WIDTH-1:0] Rdata2,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic             Stall,
  output logic [WIDTH-1:0] ReadData,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Two's-complement negation of a single-width value.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    neg_w = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Two's-complement negation of a double-width value.
  function automatic logic [2*WIDTH-1:0] neg_dw(input logic [2*WIDTH-1:0] v);
    neg_dw = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  // acc_r: multiply -> {partial product high, multiplier shifting out}
  //        divide   -> {remainder, dividend shifting out / quotient shifting in}
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   opnd_r;     // multiplicand or divisor magnitude
  logic               is_div_r;
  logic               neg_res_r;  // negate product / quotient
  logic               neg_rem_r;  // negate remainder (dividend was negative)
  logic               dz_r;       // divide by zero
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;

  logic               is_signed_s;
  logic               is_muldiv_s;
  logic               is_div_op_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_abs_s;
  logic [WIDTH-1:0]   b_abs_s;

  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     rem_shift_s;
  logic [WIDTH:0]     div_trial_s;
  logic [2*WIDTH-1:0] acc_next_s;

  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;
  logic [WIDTH-1:0]   fix_hi_s;
  logic [WIDTH-1:0]   fix_lo_s;

  assign Busy     = busy_r;
  assign Done     = done_r;
  assign Hi       = hi_r;
  assign Lo       = lo_r;
  assign Stall    = Start & busy_r;
  assign ReadData = (Funct == F_MFHI) ? hi_r : lo_r;

  // Decode the incoming request and form operand magnitudes for signed ops.
  always_comb begin
    is_signed_s = (Funct == F_MULT) || (Funct == F_DIV);
    is_div_op_s = (Funct == F_DIV)  || (Funct == F_DIVU);
    is_muldiv_s = (Funct == F_MULT) || (Funct == F_MULTU) || is_div_op_s;
    a_neg_s     = is_signed_s & Rdata1[WIDTH-1];
    b_neg_s     = is_signed_s & Rdata2[WIDTH-1];
    if (a_neg_s) begin
      a_abs_s = neg_w(Rdata1);
    end else begin
      a_abs_s = Rdata1;
    end
    if (b_neg_s) begin
      b_abs_s = neg_w(Rdata2);
    end else begin
      b_abs_s = Rdata2;
    end
  end

  // One radix-2 iteration: shift-add multiply or restoring divide.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
    rem_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_trial_s = rem_shift_s - {1'b0, opnd_r};
    acc_next_s  = acc_r;
    if (is_div_r) begin
      if (!div_trial_s[WIDTH]) begin
        acc_next_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_next_s = {rem_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc_r[0]) begin
        acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
      end else begin
        acc_next_s = {1'b0, acc_r[2*WIDTH-1:1]};
      end
    end
  end

  // Sign correction applied in the FIX cycle.
  always_comb begin
    if (neg_res_r) begin
      prod_fix_s = neg_dw(acc_r);
    end else begin
      prod_fix_s = acc_r;
    end
    if (dz_r) begin
      quo_fix_s = {WIDTH{1'b1}};
    end else if (neg_res_r) begin
      quo_fix_s = neg_w(acc_r[WIDTH-1:0]);
    end else begin
      quo_fix_s = acc_r[WIDTH-1:0];
    end
    if (neg_rem_r) begin
      rem_fix_s = neg_w(acc_r[2*WIDTH-1:WIDTH]);
    end else begin
      rem_fix_s = acc_r[2*WIDTH-1:WIDTH];
    end
    if (is_div_r) begin
      fix_hi_s = rem_fix_s;
      fix_lo_s = quo_fix_s;
    end else begin
      fix_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_fix_s[WIDTH-1:0];
    end
  end

  // Sequencer: request acceptance, iteration, sign fix-up and HI/LO writes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      opnd_r    <= {WIDTH{1'b0}};
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      dz_r      <= 1'b0;
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (Start && !Flush) begin
            if (is_muldiv_s) begin
              acc_r     <= {{WIDTH{1'b0}}, a_abs_s};
              opnd_r    <= b_abs_s;
              is_div_r  <= is_div_op_s;
              neg_res_r <= a_neg_s ^ b_neg_s;
              neg_rem_r <= is_div_op_s & a_neg_s;
              dz_r      <= is_div_op_s & (Rdata2 == {WIDTH{1'b0}});
              cnt_r     <= {CNT_W{1'b0}};
              busy_r    <= 1'b1;
              state_r   <= ST_CALC;
            end else if (Funct == F_MTHI) begin
              hi_r <= Rdata1;
            end else if (Funct == F_MTLO) begin
              lo_r <= Rdata1;
            end else begin
              // MFHI/MFLO read combinationally; other functs are ignored.
              state_r <= ST_IDLE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CALC: begin
          if (Flush) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_r == {CNT_W{1'b1}}) begin
              state_r <= ST_FIX;
            end else begin
              state_r <= ST_CALC;
            end
          end
        end
        ST_FIX: begin
          // A kill here wins over the HI/LO write.
          if (Flush) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            hi_r    <= fix_hi_s;
            lo_r    <= fix_lo_s;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed timing/stall/flush/reset scenarios
// plus randomized HI/LO traffic, checked by a scoreboard fed from a
// plain-arithmetic reference model.
`timescale 1ns/1ps

module tb_muldiv_unit;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic        CLK = 1'b0;
  logic        RST, Start, Flush;
  logic [5:0]  Funct;
  logic [31:0] Rdata1, Rdata2;
  logic        Busy, Done, Stall;
  logic [31:0] ReadData, Hi, Lo;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_v;
  logic [31:0] m_hi, m_lo;

  muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Funct(Funct),
    .Rdata1(Rdata1), .Rdata2(Rdata2), .Flush(Flush),
    .Busy(Busy), .Done(Done), .Stall(Stall),
    .ReadData(ReadData), .Hi(Hi), .Lo(Lo)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp_v);
    end
  endtask

  // Reference model: {HI, LO} from the architectural rules, using 64-bit arithmetic.
  function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = 64'd0;
    case (f)
      F_MULT:  p = 64'(sa * sb);
      F_MULTU: p = {32'd0, a} * {32'd0, b};
      F_DIV: begin
        if (b == 32'd0) p = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      F_DIVU: begin
        if (b == 32'd0) p = {a, 32'hFFFFFFFF};
        else p = {a % b, a / b};
      end
      default: p = 64'd0;
    endcase
    return p;
  endfunction

  // Scoreboard monitor: every Done pulse must match the oldest expected result.
  always @(negedge CLK) begin
    if (Done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected actual Hi=%h Lo=%h required no Done pulse", Hi, Lo);
      end else begin
        mon_v = exp_q.pop_front();
        chk("result_hi", {32'd0, Hi}, {32'd0, mon_v[63:32]});
        chk("result_lo", {32'd0, Lo}, {32'd0, mon_v[31:0]});
      end
    end
  end

  // Present one request as EX would: hold it until Stall drops, then retire it.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic use_exp, input logic [63:0] exp_v);
    int n;
    logic [63:0] v;
    Start = 1'b1; Funct = f; Rdata1 = a; Rdata2 = b;
    n = 0;
    @(negedge CLK);
    while (Busy && n < 200) begin
      n++;
      @(negedge CLK);
    end
    if (Busy) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout actual Busy=1 after %0d cycles required Busy=0", n);
    end
    case (f)
      F_MFHI: chk("mfhi_readdata", {32'd0, ReadData}, {32'd0, m_hi});
      F_MFLO: chk("mflo_readdata", {32'd0, ReadData}, {32'd0, m_lo});
      F_MTHI: m_hi = a;
      F_MTLO: m_lo = a;
      F_MULT, F_MULTU, F_DIV, F_DIVU: begin
        v = use_exp ? exp_v : ref_op(f, a, b);
        exp_q.push_back(v);
        m_hi = v[63:32];
        m_lo = v[31:0];
      end
      default: ;
    endcase
    @(posedge CLK); #1;
    Start = 1'b0;
  endtask

  // Wait (bounded) for the unit to go idle with all results checked.
  task automatic wait_idle();
    int n;
    n = 0;
    while ((Busy || exp_q.size() != 0) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (Busy || exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual Busy=%0b pending=%0d required idle", Busy, exp_q.size());
    end
    @(posedge CLK); #1;
  endtask

  function automatic logic [31:0] pick_val();
    int r;
    r = $urandom_range(0, 5);
    case (r)
      0: return 32'h00000000;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  logic [5:0]  f_tab  [6] = '{F_MULTU, F_MULT, F_DIV, F_DIVU, F_DIVU, F_DIV};
  logic [31:0] a_tab  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'd5, 32'h80000000};
  logic [31:0] b_tab  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd0, 32'hFFFFFFFF};
  logic [31:0] hi_tab [6] = '{32'hFFFFFFFE, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd5, 32'd0};
  logic [31:0] lo_tab [6] = '{32'd1, 32'd1, 32'hFFFFFFFD, 32'd3, 32'hFFFFFFFF, 32'h80000000};
  logic [5:0]  rnd_f  [9] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO, F_MTHI, F_MTLO, 6'h00};

  // Hard stop in case something never returns.
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles, stall_cycles, d0;
    RST = 1'b1; Start = 1'b0; Flush = 1'b0; Funct = 6'h00; Rdata1 = 32'd0; Rdata2 = 32'd0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("reset_hi", {32'd0, Hi}, 64'd0);
    chk("reset_lo", {32'd0, Lo}, 64'd0);
    chk("reset_busy", {63'd0, Busy}, 64'd0);
    chk("reset_done", {63'd0, Done}, 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;

    // MULT -3 x 5: latency and Busy window.
    @(posedge CLK); #1;
    Start = 1'b1; Funct = F_MULT; Rdata1 = 32'hFFFFFFFD; Rdata2 = 32'd5;
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFF1});
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFF1;
    @(negedge CLK);
    @(posedge CLK); #1 Start = 1'b0;
    busy_cycles = 0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge CLK);
      if (Busy) busy_cycles++;
    end
    chk("busy_window", 64'(busy_cycles), 64'd33);
    @(negedge CLK);
    chk("n34_busy", {63'd0, Busy}, 64'd0);
    chk("n34_done", {63'd0, Done}, 64'd1);
    chk("n34_hi", {32'd0, Hi}, {32'd0, 32'hFFFFFFFF});
    chk("n34_lo", {32'd0, Lo}, {32'd0, 32'hFFFFFFF1});
    @(posedge CLK); #1;

    // Boundary cases, issued back-to-back, then read back through MFHI/MFLO.
    for (int i = 0; i < 6; i++) begin
      issue(f_tab[i], a_tab[i], b_tab[i], 1'b1, {hi_tab[i], lo_tab[i]});
    end
    issue(F_MFHI, 32'd0, 32'd0, 1'b0, 64'd0);
    issue(F_MFLO, 32'd0, 32'd0, 1'b0, 64'd0);
    wait_idle();

    // MULT 6x7 with MFLO held from N+5: Stall window and readback.
    Start = 1'b1; Funct = F_MULT; Rdata1 = 32'd6; Rdata2 = 32'd7;
    exp_q.push_back(64'd42);
    m_hi = 32'd0; m_lo = 32'd42;
    @(negedge CLK);
    @(posedge CLK); #1 Start = 1'b0;
    repeat (4) begin @(posedge CLK); #1; end
    Start = 1'b1; Funct = F_MFLO;
    stall_cycles = 0;
    for (int k = 5; k <= 33; k++) begin
      @(negedge CLK);
      if (Stall) stall_cycles++;
    end
    chk("stall_window", 64'(stall_cycles), 64'd29);
    @(negedge CLK);
    chk("stall_release", {63'd0, Stall}, 64'd0);
    chk("mflo_after_stall", {32'd0, ReadData}, 64'd42);
    @(posedge CLK); #1;
    Funct = F_MTHI; Rdata1 = 32'h00001234;
    @(posedge CLK); #1 Start = 1'b0;
    m_hi = 32'h00001234;
    @(negedge CLK);
    chk("mthi_hi", {32'd0, Hi}, {32'd0, 32'h00001234});
    chk("mthi_lo_kept", {32'd0, Lo}, 64'd42);
    chk("mthi_no_busy", {63'd0, Busy}, 64'd0);
    @(posedge CLK); #1;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 24; i++) begin
      issue(rnd_f[$urandom_range(0, 8)], pick_val(), pick_val(), 1'b0, 64'd0);
    end
    wait_idle();
    chk("final_hi", {32'd0, Hi}, {32'd0, m_hi});
    chk("final_lo", {32'd0, Lo}, {32'd0, m_lo});

    // DIV 100/3 flushed at N+10.
    d0 = done_cnt;
    Start = 1'b1; Funct = F_DIV; Rdata1 = 32'd100; Rdata2 = 32'd3;
    @(negedge CLK);
    @(posedge CLK); #1 Start = 1'b0;
    repeat (9) begin @(posedge CLK); #1; end
    Flush = 1'b1;
    @(posedge CLK); #1 Flush = 1'b0;
    @(negedge CLK);
    chk("flush_busy", {63'd0, Busy}, 64'd0);
    repeat (30) @(negedge CLK);
    chk("flush_no_done", 64'(done_cnt), 64'(d0));
    chk("flush_hi_kept", {32'd0, Hi}, {32'd0, m_hi});
    chk("flush_lo_kept", {32'd0, Lo}, {32'd0, m_lo});
    @(posedge CLK); #1;

    // Flush together with Start in IDLE: nothing accepted.
    Start = 1'b1; Flush = 1'b1; Funct = F_MTLO; Rdata1 = ~m_lo;
    @(posedge CLK); #1 Start = 1'b0; Flush = 1'b0;
    @(negedge CLK);
    chk("flush_start_lo", {32'd0, Lo}, {32'd0, m_lo});
    @(posedge CLK); #1;

    // DIV 100/3 again, reset at N+20.
    Start = 1'b1; Funct = F_DIV; Rdata1 = 32'd100; Rdata2 = 32'd3;
    @(negedge CLK);
    @(posedge CLK); #1 Start = 1'b0;
    repeat (19) begin @(posedge CLK); #1; end
    RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge CLK);
    chk("rst_mid_hi", {32'd0, Hi}, 64'd0);
    chk("rst_mid_lo", {32'd0, Lo}, 64'd0);
    chk("rst_mid_busy", {63'd0, Busy}, 64'd0);
    repeat (20) @(negedge CLK);
    chk("rst_mid_no_done", 64'(done_cnt), 64'(d0));
    @(posedge CLK); #1;

    // Unit still works after the mid-operation reset.
    issue(F_DIVU, 32'd100, 32'd3, 1'b0, 64'd0);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
